// File: rtl/mini_cpu_pkg.sv
// -----------------------------------------------------------------------------
// mini_cpu_pkg
// Shared constants, types and small helpers for the mini-CPU pipeline.
//   DATA_W      : data / address width
//   RD_W        : destination-register index width
//   mem_state_t : MEM-stage load sequencer states
//   addr_in_range : unsigned address-vs-depth range check
// -----------------------------------------------------------------------------
package mini_cpu_pkg;

    localparam int DATA_W = 8;
    localparam int RD_W   = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mem_state_t;

    // True when the (zero-extended) address indexes an existing memory entry.
    function automatic logic addr_in_range(input logic [31:0] addr, input logic [31:0] depth);
        return (addr < depth);
    endfunction

endpackage : mini_cpu_pkg

// File: rtl/mem_stage_data_mem.sv
// -----------------------------------------------------------------------------
// data_mem
// DEPTH x DATA_W data memory for the MEM stage.
//   clk   : rising-edge clock
//   we    : write enable, write happens at the clock edge
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : registered read data, valid one cycle after raddr is presented
// Contents are never cleared by reset.
// -----------------------------------------------------------------------------
module data_mem #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 256,
    parameter int AW     = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_r [DEPTH];

    // Synchronous write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    // Registered read port.
    always_ff @(posedge clk) begin
        rdata <= mem_r[raddr];
    end

endmodule : data_mem

// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage
// MEM stage of the mini-CPU pipeline, between the EX/MEM register and mem_wb.
// Stores complete in a single cycle; loads stall the upstream pipeline for
// LATENCY cycles and then present their result for exactly one cycle.
// Outputs are combinational and are registered by mem_wb.
//   clk, rst        : clock, synchronous active-high reset
//   mem_read_in     : load request (wins over mem_write_in)
//   mem_write_in    : store request
//   alu_result_in   : ALU result, also the memory address
//   store_data_in   : store data
//   rd_in, we_rf_in : destination register and its write enable
//   stall_out       : upstream hold while a load is in flight
//   mem_data_out    : load data (0 when not a load result)
//   alu_result_out  : ALU result / load address
//   rd_out          : destination register
//   we_rf_out       : register-file write enable, 0 during bubbles
//   addr_err_out    : out-of-range address on a presented store or a load result
// Assumes DEPTH <= 2**DATA_W so the memory index fits inside the address.
// -----------------------------------------------------------------------------
module mem_stage #(
    parameter int DATA_W  = mini_cpu_pkg::DATA_W,
    parameter int RD_W    = mini_cpu_pkg::RD_W,
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_read_in,
    input  logic              mem_write_in,
    input  logic [DATA_W-1:0] alu_result_in,
    input  logic [DATA_W-1:0] store_data_in,
    input  logic [RD_W-1:0]   rd_in,
    input  logic              we_rf_in,
    output logic              stall_out,
    output logic [DATA_W-1:0] mem_data_out,
    output logic [DATA_W-1:0] alu_result_out,
    output logic [RD_W-1:0]   rd_out,
    output logic              we_rf_out,
    output logic              addr_err_out
);

    import mini_cpu_pkg::*;

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // Counter only ever holds LATENCY-1 down to 0.
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [31:0]   DEPTH_U  = 32'(DEPTH);

    mem_state_t        state_r;
    logic [CW-1:0]     cnt_r;
    logic [DATA_W-1:0] addr_r;
    logic [RD_W-1:0]   rd_r;
    logic              we_rf_r;
    logic              err_r;

    logic              in_range_s;
    logic              is_store_s;
    logic              mem_we_s;
    logic [AW-1:0]     mem_raddr_s;
    logic [DATA_W-1:0] rdata_s;

    logic              stall_s;
    logic [DATA_W-1:0] mem_data_s;
    logic [DATA_W-1:0] alu_result_s;
    logic [RD_W-1:0]   rd_s;
    logic              we_rf_s;
    logic              addr_err_s;

    // Request decode: a simultaneous read wins, so a store is write-only.
    always_comb begin
        in_range_s = addr_in_range(32'(alu_result_in), DEPTH_U);
        is_store_s = mem_write_in & ~mem_read_in;
        mem_we_s   = (state_r == IDLE) & is_store_s & in_range_s & ~rst;
        // The load's first stall cycle already addresses memory so the
        // registered read is ready when the sequencer reaches DONE.
        if (state_r == IDLE) begin
            mem_raddr_s = alu_result_in[AW-1:0];
        end else begin
            mem_raddr_s = addr_r[AW-1:0];
        end
    end

    data_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_data_mem (
        .clk   (clk),
        .we    (mem_we_s),
        .waddr (alu_result_in[AW-1:0]),
        .wdata (store_data_in),
        .raddr (mem_raddr_s),
        .rdata (rdata_s)
    );

    // Load sequencer: latch the request, count the stall, emit one result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            cnt_r   <= CNT_ZERO;
            addr_r  <= {DATA_W{1'b0}};
            rd_r    <= {RD_W{1'b0}};
            we_rf_r <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (mem_read_in) begin
                        addr_r  <= alu_result_in;
                        rd_r    <= rd_in;
                        we_rf_r <= we_rf_in;
                        err_r   <= ~in_range_s;
                        cnt_r   <= CNT_INIT;
                        state_r <= (LATENCY == 1) ? DONE : BUSY;
                    end
                end
                BUSY: begin
                    cnt_r <= cnt_r - CNT_ONE;
                    if (cnt_r == CNT_ONE) begin
                        state_r <= DONE;
                    end
                end
                DONE: begin
                    // The load still held on the inputs is this one; do not restart it.
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                    cnt_r   <= CNT_ZERO;
                end
            endcase
        end
    end

    // Output mux per sequencer state, before the reset override.
    always_comb begin
        stall_s      = 1'b0;
        mem_data_s   = {DATA_W{1'b0}};
        alu_result_s = alu_result_in;
        rd_s         = rd_in;
        we_rf_s      = we_rf_in;
        addr_err_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (mem_read_in) begin
                    stall_s = 1'b1;
                    we_rf_s = 1'b0;
                end else if (mem_write_in) begin
                    addr_err_s = ~in_range_s;
                end else begin
                    addr_err_s = 1'b0;
                end
            end
            BUSY: begin
                stall_s      = 1'b1;
                we_rf_s      = 1'b0;
                alu_result_s = addr_r;
                rd_s         = rd_r;
            end
            DONE: begin
                // Out-of-range index bits may alias real entries; return 0 instead.
                if (err_r) begin
                    mem_data_s = {DATA_W{1'b0}};
                end else begin
                    mem_data_s = rdata_s;
                end
                alu_result_s = addr_r;
                rd_s         = rd_r;
                we_rf_s      = we_rf_r;
                addr_err_s   = err_r;
            end
            default: begin
                we_rf_s = 1'b0;
            end
        endcase
    end

    // Reset squashes every control-bearing output in the same cycle.
    always_comb begin
        alu_result_out = alu_result_s;
        rd_out         = rd_s;
        if (rst) begin
            stall_out    = 1'b0;
            we_rf_out    = 1'b0;
            mem_data_out = {DATA_W{1'b0}};
            addr_err_out = 1'b0;
        end else begin
            stall_out    = stall_s;
            we_rf_out    = we_rf_s;
            mem_data_out = mem_data_s;
            addr_err_out = addr_err_s;
        end
    end

endmodule : mem_stage

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, mr, mw, we;
    logic [7:0] alu, sd;
    logic [2:0] rd;

    logic       stall_o [2];
    logic [7:0] md_o    [2];
    logic [7:0] alu_o   [2];
    logic [2:0] rd_o    [2];
    logic       we_o    [2];
    logic       err_o   [2];

    mem_stage #(.DATA_W(8), .RD_W(3), .DEPTH(256), .LATENCY(2)) dut (
        .clk(clk), .rst(rst), .mem_read_in(mr), .mem_write_in(mw),
        .alu_result_in(alu), .store_data_in(sd), .rd_in(rd), .we_rf_in(we),
        .stall_out(stall_o[0]), .mem_data_out(md_o[0]), .alu_result_out(alu_o[0]),
        .rd_out(rd_o[0]), .we_rf_out(we_o[0]), .addr_err_out(err_o[0]));

    mem_stage #(.DATA_W(8), .RD_W(3), .DEPTH(16), .LATENCY(1)) dut16 (
        .clk(clk), .rst(rst), .mem_read_in(mr), .mem_write_in(mw),
        .alu_result_in(alu), .store_data_in(sd), .rd_in(rd), .we_rf_in(we),
        .stall_out(stall_o[1]), .mem_data_out(md_o[1]), .alu_result_out(alu_o[1]),
        .rd_out(rd_o[1]), .we_rf_out(we_o[1]), .addr_err_out(err_o[1]));

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model: a pending load completes LATENCY cycles after it was accepted.
    int         depth_k [2] = '{256, 16};
    int         lat_k   [2] = '{2, 1};
    bit         pend    [2];
    int         st      [2];
    logic [7:0] laddr   [2];
    logic [2:0] lrd     [2];
    bit         lwe     [2];
    bit         exp_stall [2];
    logic [7:0] mm [2][256];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            bit         e_st, e_we, e_err, fwd;
            logic [7:0] e_md, e_alu;
            logic [2:0] e_rd;
            e_st = 1'b0; e_we = 1'b0; e_err = 1'b0; fwd = 1'b0;
            e_md = 8'h00; e_alu = alu; e_rd = rd;
            if (rst) begin
                pend[k] = 1'b0;
            end else if (pend[k] && (cyc < st[k] + lat_k[k])) begin
                e_st = 1'b1;
            end else if (pend[k]) begin
                e_err   = !(laddr[k] < depth_k[k]);
                e_md    = e_err ? 8'h00 : mm[k][laddr[k]];
                e_alu   = laddr[k];
                e_rd    = lrd[k];
                e_we    = lwe[k];
                fwd     = 1'b1;
                pend[k] = 1'b0;
            end else if (mr) begin
                e_st     = 1'b1;
                pend[k]  = 1'b1;
                st[k]    = cyc;
                laddr[k] = alu;
                lrd[k]   = rd;
                lwe[k]   = we;
            end else begin
                fwd  = 1'b1;
                e_we = we;
                if (mw) begin
                    if (alu < depth_k[k]) mm[k][alu] = sd;
                    else e_err = 1'b1;
                end
            end
            chk($sformatf("m%0d_stall", k), 32'(stall_o[k]), 32'(e_st));
            chk($sformatf("m%0d_we", k), 32'(we_o[k]), 32'(e_we));
            chk($sformatf("m%0d_data", k), 32'(md_o[k]), 32'(e_md));
            chk($sformatf("m%0d_err", k), 32'(err_o[k]), 32'(e_err));
            if (fwd) begin
                chk($sformatf("m%0d_alu", k), 32'(alu_o[k]), 32'(e_alu));
                chk($sformatf("m%0d_rd", k), 32'(rd_o[k]), 32'(e_rd));
            end
            exp_stall[k] = e_st;
        end
        cyc++;
    endtask

    task automatic to_neg();
        @(negedge clk);
    endtask

    task automatic finish_cycle();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        to_neg();
        finish_cycle();
    endtask

    task automatic drive(input logic r, input logic w, input logic [7:0] a,
                         input logic [7:0] d, input logic [2:0] rr, input logic e);
        mr = r; mw = w; alu = a; sd = d; rd = rr; we = e;
    endtask

    typedef struct {
        logic       mr, mw;
        logic [7:0] alu, sd;
        logic [2:0] rd;
        logic       we;
        logic       e_st;
        logic [7:0] e_md, e_alu;
        logic [2:0] e_rd;
        logic       e_we, e_err;
    } vec_t;

    vec_t tbl [20];

    initial begin
        // Directed vectors for the DEPTH=256 / LATENCY=2 instance (memory pre-filled with a^5A).
        tbl[0]  = '{1'b0, 1'b0, 8'h3C, 8'h00, 3'd5, 1'b1, 1'b0, 8'h00, 8'h3C, 3'd5, 1'b1, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 8'h10, 8'hA5, 3'd0, 1'b0, 1'b0, 8'h00, 8'h10, 3'd0, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 8'h10, 8'h00, 3'd2, 1'b1, 1'b1, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, 8'h10, 8'h00, 3'd2, 1'b1, 1'b1, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 1'b0, 8'h10, 8'h00, 3'd2, 1'b1, 1'b0, 8'hA5, 8'h10, 3'd2, 1'b1, 1'b0};
        tbl[5]  = '{1'b0, 1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 1'b0, 8'h01, 8'h00, 3'd3, 1'b1, 1'b1, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, 1'b0, 8'h01, 8'h00, 3'd3, 1'b1, 1'b1, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, 1'b0, 8'h01, 8'h00, 3'd3, 1'b1, 1'b0, 8'h5B, 8'h01, 3'd3, 1'b1, 1'b0};
        tbl[9]  = '{1'b1, 1'b0, 8'h02, 8'h00, 3'd4, 1'b1, 1'b1, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0};
        tbl[10] = '{1'b1, 1'b0, 8'h02, 8'h00, 3'd4, 1'b1, 1'b1, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0};
        tbl[11] = '{1'b1, 1'b0, 8'h02, 8'h00, 3'd4, 1'b1, 1'b0, 8'h58, 8'h02, 3'd4, 1'b1, 1'b0};
        tbl[12] = '{1'b0, 1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0};
        tbl[13] = '{1'b1, 1'b1, 8'h20, 8'hFF, 3'd1, 1'b1, 1'b1, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0};
        tbl[14] = '{1'b1, 1'b1, 8'h20, 8'hFF, 3'd1, 1'b1, 1'b1, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0};
        tbl[15] = '{1'b1, 1'b1, 8'h20, 8'hFF, 3'd1, 1'b1, 1'b0, 8'h7A, 8'h20, 3'd1, 1'b1, 1'b0};
        tbl[16] = '{1'b1, 1'b0, 8'h20, 8'h00, 3'd1, 1'b1, 1'b1, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0};
        tbl[17] = '{1'b1, 1'b0, 8'h20, 8'h00, 3'd1, 1'b1, 1'b1, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0};
        tbl[18] = '{1'b1, 1'b0, 8'h20, 8'h00, 3'd1, 1'b1, 1'b0, 8'h7A, 8'h20, 3'd1, 1'b1, 1'b0};
        tbl[19] = '{1'b0, 1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0};

        // Reset: outputs forced low.
        rst = 1'b1;
        drive(1'b0, 1'b0, 8'h00, 8'h00, 3'd0, 1'b1);
        to_neg();
        chk("rst_stall", 32'(stall_o[0]), 32'd0);
        chk("rst_we", 32'(we_o[0]), 32'd0);
        finish_cycle();
        tick();
        rst = 1'b0;

        // Fill memory through the store path; DEPTH=16 instance flags a>=16.
        for (int a = 0; a < 256; a++) begin
            drive(1'b0, 1'b1, 8'(a), 8'(a) ^ 8'h5A, 3'd0, 1'b0);
            tick();
        end

        // Table-driven directed vectors.
        for (int i = 0; i < 20; i++) begin
            drive(tbl[i].mr, tbl[i].mw, tbl[i].alu, tbl[i].sd, tbl[i].rd, tbl[i].we);
            to_neg();
            chk("tbl_stall", 32'(stall_o[0]), 32'(tbl[i].e_st));
            chk("tbl_data", 32'(md_o[0]), 32'(tbl[i].e_md));
            chk("tbl_we", 32'(we_o[0]), 32'(tbl[i].e_we));
            chk("tbl_err", 32'(err_o[0]), 32'(tbl[i].e_err));
            if (!tbl[i].e_st) begin
                chk("tbl_alu", 32'(alu_o[0]), 32'(tbl[i].e_alu));
                chk("tbl_rd", 32'(rd_o[0]), 32'(tbl[i].e_rd));
            end
            finish_cycle();
        end
        drive(1'b0, 1'b0, 8'h00, 8'h00, 3'd0, 1'b0);
        tick();
        tick();

        // Out-of-range load / store on the DEPTH=16, LATENCY=1 instance.
        drive(1'b1, 1'b0, 8'h40, 8'h00, 3'd6, 1'b1);
        to_neg();
        chk("oor_ld_stall", 32'(stall_o[1]), 32'd1);
        finish_cycle();
        to_neg();
        chk("oor_ld_stall_done", 32'(stall_o[1]), 32'd0);
        chk("oor_ld_data", 32'(md_o[1]), 32'h00);
        chk("oor_ld_err", 32'(err_o[1]), 32'd1);
        chk("oor_ld_rd", 32'(rd_o[1]), 32'd6);
        finish_cycle();
        to_neg();
        chk("ld40_data_d256", 32'(md_o[0]), 32'h1A);
        chk("ld40_err_d256", 32'(err_o[0]), 32'd0);
        finish_cycle();
        drive(1'b0, 1'b0, 8'h00, 8'h00, 3'd0, 1'b0);
        tick();
        drive(1'b0, 1'b1, 8'h40, 8'h77, 3'd0, 1'b0);
        to_neg();
        chk("oor_st_err", 32'(err_o[1]), 32'd1);
        chk("oor_st_stall", 32'(stall_o[1]), 32'd0);
        finish_cycle();
        drive(1'b0, 1'b0, 8'h00, 8'h00, 3'd0, 1'b0);
        tick();

        // Reset during BUSY abandons the load; memory survives.
        drive(1'b1, 1'b0, 8'h10, 8'h00, 3'd2, 1'b1);
        to_neg();
        chk("rbusy_stall0", 32'(stall_o[0]), 32'd1);
        finish_cycle();
        rst = 1'b1;
        to_neg();
        chk("rbusy_stall_in_rst", 32'(stall_o[0]), 32'd0);
        finish_cycle();
        rst = 1'b0;
        drive(1'b0, 1'b0, 8'h00, 8'h00, 3'd0, 1'b0);
        to_neg();
        chk("rbusy_stall_after", 32'(stall_o[0]), 32'd0);
        chk("rbusy_we_after", 32'(we_o[0]), 32'd0);
        finish_cycle();
        drive(1'b1, 1'b0, 8'h10, 8'h00, 3'd2, 1'b1);
        tick();
        tick();
        to_neg();
        chk("rbusy_mem_kept", 32'(md_o[0]), 32'hA5);
        finish_cycle();
        drive(1'b0, 1'b0, 8'h00, 8'h00, 3'd0, 1'b0);
        tick();

        // Randomized traffic; inputs held while either model expects a stall.
        for (int n = 0; n < 600; n++) begin
            if (!(exp_stall[0] || exp_stall[1])) begin
                int unsigned op;
                op = $urandom_range(0, 3);
                mr = op[1];
                mw = op[0];
                alu = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 23));
                sd = 8'($urandom_range(0, 255));
                rd = 3'($urandom_range(0, 7));
                we = 1'($urandom_range(0, 1));
            end
            rst = ($urandom_range(0, 49) == 0);
            tick();
        end
        rst = 1'b0;
        drive(1'b0, 1'b0, 8'h00, 8'h00, 3'd0, 1'b0);
        tick();
        tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_mem_stage
